// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared constants and state encoding for the program loader
// PROG_WORDS is also used to size the external writable program memory.
package prog_loader_pkg;

   localparam int PL_AW      = 10;
   localparam int PL_DW      = 16;
   localparam int PROG_WORDS = 2 ** PL_AW;
   localparam int LEN_W      = 11;

   localparam logic [2:0] S_LEN_HI = 3'd0;
   localparam logic [2:0] S_LEN_LO = 3'd1;
   localparam logic [2:0] S_W_HI   = 3'd2;
   localparam logic [2:0] S_W_LO   = 3'd3;
   localparam logic [2:0] S_CHK    = 3'd4;
   localparam logic [2:0] S_RUN    = 3'd5;
   localparam logic [2:0] S_ERROR  = 3'd6;

   typedef enum logic [2:0] {
      LEN_HI = S_LEN_HI,
      LEN_LO = S_LEN_LO,
      W_HI   = S_W_HI,
      W_LO   = S_W_LO,
      CHK    = S_CHK,
      RUN    = S_RUN,
      ERROR  = S_ERROR
   } state_t;

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream boot loader writing 16-bit words into program memory
// Optional LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte (CHK state).
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int AW = PL_AW,
   parameter int DW = PL_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          reload,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_wa,
   output logic [DW-1:0] mem_wd,
   output logic          cpu_run,
   output logic          busy,
   output logic          error
);

   localparam int WORDS = 2 ** AW;

   state_t            r_state;
   state_t            w_next;
   logic              r_first;
   logic [7:0]        r_hi;
   logic [LEN_W-1:0]  r_len;
   logic [LEN_W-1:0]  r_cnt;
   logic [AW-1:0]     r_addr;
   logic              r_mem_we;
   logic [AW-1:0]     r_mem_wa;
   logic [DW-1:0]     r_mem_wd;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        r_sum;
`endif

   logic              w_load;
   logic              w_ready;
   logic              w_acc;
   logic              w_idle_end;
   logic [LEN_W-1:0]  w_len;
   logic              w_len_ok;
   logic              w_last;

   assign w_load     = (r_state != RUN) && (r_state != ERROR);
   assign w_ready    = w_load && !r_first;
   assign w_acc      = in_valid && w_ready;
   assign w_idle_end = !w_load && reload;
   assign w_len      = {r_hi[2:0], in_data};
   assign w_len_ok   = (w_len != '0) && ({1'b0, w_len} <= 12'(WORDS));
   assign w_last     = (r_cnt + 11'd1) == r_len;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= LEN_HI;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         LEN_HI: if (w_acc) w_next = LEN_LO;
         LEN_LO: if (w_acc) w_next = w_len_ok ? W_HI : ERROR;
         W_HI:   if (w_acc) w_next = W_LO;
         W_LO: begin
            if (w_acc) begin
`ifdef LOADER_CHECKSUM_EN
               w_next = w_last ? CHK : W_HI;
`else
               w_next = w_last ? RUN : W_HI;
`endif
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CHK: if (w_acc) w_next = ((r_sum + in_data) == 8'h00) ? RUN : ERROR;
`endif
         RUN:    if (reload) w_next = LEN_HI;
         ERROR:  if (reload) w_next = LEN_HI;
         default: w_next = LEN_HI;
      endcase
   end

   // r_hi holds the length high byte during LEN_LO and the word high byte during W_LO.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_first  <= 1'b1;
         r_hi     <= '0;
         r_len    <= '0;
         r_cnt    <= '0;
         r_addr   <= '0;
         r_mem_we <= 1'b0;
         r_mem_wa <= '0;
         r_mem_wd <= '0;
`ifdef LOADER_CHECKSUM_EN
         r_sum    <= '0;
`endif
      end else begin
         r_first  <= 1'b0;
         r_mem_we <= 1'b0;
         if (w_acc) begin
`ifdef LOADER_CHECKSUM_EN
            r_sum <= r_sum + in_data;
`endif
            case (r_state)
               LEN_HI: r_hi  <= in_data;
               LEN_LO: r_len <= w_len;
               W_HI:   r_hi  <= in_data;
               W_LO: begin
                  r_mem_we <= 1'b1;
                  r_mem_wa <= r_addr;
                  r_mem_wd <= DW'({r_hi, in_data});
                  r_addr   <= r_addr + AW'(1);
                  r_cnt    <= r_cnt + 11'd1;
               end
               default: ;
            endcase
         end
         if (w_idle_end) begin
            r_addr <= '0;
            r_cnt  <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_sum  <= '0;
`endif
         end
      end
   end

   assign in_ready = w_ready;
   assign mem_we   = r_mem_we;
   assign mem_wa   = r_mem_wa;
   assign mem_wd   = r_mem_wd;
   // The final write pulse lands in the first RUN cycle; hold the CPU off until it is done.
   assign cpu_run  = (r_state == RUN) && !r_mem_we;
   assign busy     = w_load;
   assign error    = (r_state == ERROR);

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader with a stream-level reference model
// Define LOADER_CHECKSUM_EN for both bench and RTL to exercise the checksum build.
module tb_prog_loader;

   typedef logic [7:0] bq_t[$];

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       reload = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       mem_we;
   logic [9:0] mem_wa;
   logic [15:0] mem_wd;
   logic       cpu_run;
   logic       busy;
   logic       error;

   prog_loader dut (
      .clk      (clk),
      .reset    (reset),
      .reload   (reload),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .mem_we   (mem_we),
      .mem_wa   (mem_wa),
      .mem_wd   (mem_wd),
      .cpu_run  (cpu_run),
      .busy     (busy),
      .error    (error)
   );

   always #5 clk = ~clk;

   logic [25:0] exp_q[$];
   logic [25:0] mon_e;
   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int last_we = -100;
   logic prev_run = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every write pulse must match the head of the expected-write queue.
   always @(negedge clk) begin
      cyc++;
      if (mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_wa, mem_wd);
         end else begin
            mon_e = exp_q.pop_front();
            check("write_addr", {22'd0, mem_wa}, {22'd0, mon_e[25:16]});
            check("write_data", {16'd0, mem_wd}, {16'd0, mon_e[15:0]});
         end
         last_we = cyc;
      end
`ifndef LOADER_CHECKSUM_EN
      if (cpu_run && !prev_run && reset)
         check("run_after_last_we", cyc - last_we, 1);
`endif
      prev_run = cpu_run;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic bq_t with_chk(input bq_t s);
      bq_t r = s;
`ifdef LOADER_CHECKSUM_EN
      logic [7:0] sum = 8'd0;
      foreach (r[i]) sum += r[i];
      r.push_back(8'd0 - sum);
`endif
      return r;
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n = 0;
      in_data  = b;
      in_valid = 1'b1;
      @(negedge clk);
      while (in_ready !== 1'b1) begin
         n++;
         if (n > 50) begin
            check("send_timeout", 0, 1);
            in_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      for (int i = 0; i < gap; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reference model: decode the stream as the loader's protocol defines it.
   task automatic run_load(input bq_t s, input int gap_mode, input string tag);
      int   len;
      int   nsend;
      int   n;
      logic exp_run;
      len     = int'(s[0] & 8'h07) * 256 + int'(s[1]);
      exp_run = (len >= 1) && (len <= 1024);
      nsend   = 2;
      if (exp_run) begin
         for (int i = 0; i < len; i++)
            exp_q.push_back({10'(i), s[2 + 2 * i], s[3 + 2 * i]});
         nsend = 2 + 2 * len;
`ifdef LOADER_CHECKSUM_EN
         begin
            logic [7:0] sum = 8'd0;
            for (int i = 0; i <= nsend; i++) sum += s[i];
            exp_run = (sum == 8'd0);
            nsend++;
         end
`endif
      end
      for (int i = 0; i < nsend; i++)
         send_byte(s[i], (gap_mode == 2) ? int'($urandom_range(0, 2)) : gap_mode);
      n = 0;
      @(negedge clk);
      while (!cpu_run && !error && n < 40) begin
         n++;
         @(negedge clk);
      end
      check({tag, "_cpu_run"}, cpu_run, exp_run);
      check({tag, "_error"}, error, !exp_run);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_pending_writes"}, exp_q.size(), 0);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      check({tag, "_hold_cpu_run"}, cpu_run, exp_run);
      check({tag, "_hold_error"}, error, !exp_run);
   endtask

   task automatic do_reload(input string tag);
      reload = 1'b1;
      @(posedge clk);
      #1;
      reload = 1'b0;
      @(negedge clk);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_error"}, error, 0);
      check({tag, "_cpu_run"}, cpu_run, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic random_load();
      bq_t s;
      int  len;
      int  kind;
      kind = int'($urandom_range(0, 5));
      if (kind == 0)      len = 0;
      else if (kind == 1) len = int'($urandom_range(1025, 2047));
      else                len = int'($urandom_range(1, 16));
      s.push_back({5'($urandom), 3'(len >> 8)});
      s.push_back(8'(len));
      if (len >= 1 && len <= 1024)
         for (int i = 0; i < 2 * len; i++) s.push_back(8'($urandom));
      s = with_chk(s);
`ifdef LOADER_CHECKSUM_EN
      if ($urandom_range(0, 3) == 0) s[s.size() - 1] ^= 8'h5A;
`endif
      run_load(s, int'($urandom_range(0, 2)), "rand");
      do_reload("rand_reload");
   endtask

   initial begin
      bq_t s;

      // Reset values, then one cycle with in_ready low after release.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_wa", mem_wa, 0);
      check("rst_mem_wd", mem_wd, 0);
      check("rst_cpu_run", cpu_run, 0);
      check("rst_busy", busy, 1);
      check("rst_error", error, 0);
      check("rst_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check("first_cycle_in_ready", in_ready, 0);
      @(negedge clk);
      check("second_cycle_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
      run_load(with_chk(s), 0, "two_words");
      do_reload("two_words_reload");

      s = '{8'h00, 8'h00};
      run_load(s, 0, "len_zero");
      do_reload("len_zero_reload");

      s = '{8'h00, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23};
      run_load(with_chk(s), 1, "toggle_valid");
      do_reload("toggle_reload");

      // Reset mid-load, just after the high byte of the sixth word.
      s = '{8'h00, 8'h08};
      for (int i = 0; i < 11; i++) s.push_back(8'($urandom));
      for (int i = 0; i < 5; i++) exp_q.push_back({10'(i), s[2 + 2 * i], s[3 + 2 * i]});
      for (int i = 0; i < 13; i++) send_byte(s[i], 0);
      #2;
      reset = 1'b0;
      #1;
      check("midrst_mem_we", mem_we, 0);
      check("midrst_mem_wa", mem_wa, 0);
      check("midrst_mem_wd", mem_wd, 0);
      check("midrst_cpu_run", cpu_run, 0);
      check("midrst_busy", busy, 1);
      check("midrst_error", error, 0);
      check("midrst_in_ready", in_ready, 0);
      check("midrst_writes_seen", exp_q.size(), 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b1;
      s = '{8'h00, 8'h01, 8'h5A, 8'hC3};
      run_load(with_chk(s), 0, "after_reset");
      do_reload("after_reset_reload");

`ifdef LOADER_CHECKSUM_EN
      s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'hB9};
      run_load(s, 0, "chk_good");
      do_reload("chk_good_reload");
      s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h00};
      run_load(s, 0, "chk_bad");
      do_reload("chk_bad_reload");
`endif

      s = '{8'h04, 8'h00};
      for (int i = 0; i < 2048; i++) s.push_back(8'($urandom));
      run_load(with_chk(s), 0, "full_1024");
      check("full_last_addr", mem_wa, 10'h3FF);
      do_reload("full_reload");

      s = '{8'h04, 8'h01};
      run_load(s, 0, "len_1025");
      do_reload("len_1025_reload");

      for (int k = 0; k < 12; k++) random_load();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
